// File: rtl/uart_rx.sv
// uart_rx: 8N1 serial receiver, LSB first, recovering bytes sent on the CPU's
// uart_rx_out line. The line is sampled at bit mid-points after a two-flop
// synchroniser; each received byte is offered on a valid/ready handshake.
//
// Ports:
//   sysclk      system clock, rising edge
//   cpu_resetn  synchronous active-low reset
//   uart_rx_in  serial line, asynchronous, idle high
//   rx_data     received byte, held stable while rx_valid is high
//   rx_valid    byte available until accepted (rx_valid && rx_ready)
//   rx_ready    consumer accept
//   frame_err   one-cycle pulse when the stop bit samples low
//   overrun     sticky: a completed byte was dropped while rx_valid was held
//   ovr_clr     clears overrun (a simultaneous new overrun wins)
//   busy        high whenever the receiver is not idle
module uart_rx #(
  parameter int CLKS_PER_BIT = 87,
  parameter int HALF_BIT     = CLKS_PER_BIT / 2
) (
  input  logic       sysclk,
  input  logic       cpu_resetn,
  input  logic       uart_rx_in,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overrun,
  input  logic       ovr_clr,
  output logic       busy
);

  localparam int          CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_RECOVER
  } state_t;

  state_t        state;
  logic          sync1;
  logic          rx_s;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shreg;
  logic          accept;

  assign accept = rx_valid && rx_ready;

  always_ff @(posedge sysclk) begin
    if (!cpu_resetn) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shreg     <= '0;
      rx_data   <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      sync1     <= uart_rx_in;
      rx_s      <= sync1;
      frame_err <= 1'b0;

      // Defaults that a later assignment in the FSM may override: a byte
      // loading on the accept edge keeps rx_valid high, and an overrun set
      // on the clear edge keeps overrun high.
      if (ovr_clr) overrun  <= 1'b0;
      if (accept)  rx_valid <= 1'b0;

      case (state)
        S_IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= S_START;
            busy  <= 1'b1;
          end
        end

        S_START: begin
          if (cnt == CNT_HALF) begin
            cnt <= '0;
            if (rx_s) begin
              // Line went back high before mid-start: treat as a glitch.
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              state   <= S_DATA;
              bit_idx <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_DATA: begin
          if (cnt == CNT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) state <= S_STOP;
            else                 bit_idx <= bit_idx + 3'd1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_STOP: begin
          if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              if (!rx_valid || accept) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
              end else begin
                overrun <= 1'b1;
              end
              state <= S_IDLE;
              busy  <= 1'b0;
            end else begin
              frame_err <= 1'b1;
              state     <= S_RECOVER;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end

        S_RECOVER: begin
          // Wait out a break so a held-low line reports only one error.
          cnt <= '0;
          if (rx_s) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= S_IDLE;
          cnt   <= '0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver, 8N1, LSB first.
- It is the receiving end of the CPU's `uart_rx_out` line. The CPU bench and the FPGA loopback harness use it to recover the bytes the CPU transmits.
- It presents each received byte on a valid/ready handshake.
- It flags framing errors and overruns.

Parameters:
- CLKS_PER_BIT, 87, sysclk cycles per bit period (10 MHz / 115200 baud, rounded). Must be >= 4.
- HALF_BIT, CLKS_PER_BIT/2, cycles from start-bit detection to the start-bit mid-sample.

Ports:
- sysclk  in  1  system clock; all logic on the rising edge.
- cpu_resetn  in  1  synchronous active-low reset.
- uart_rx_in  in  1  serial line, asynchronous to sysclk, idle high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ready  in  1  consumer accepts the byte when rx_valid && rx_ready at a rising edge.
- frame_err  out  1  one-cycle pulse when the stop bit is sampled low.
- overrun  out  1  sticky; a completed byte was dropped because rx_valid was still held.
- ovr_clr  in  1  clears overrun.
- busy  out  1  high in every state except IDLE.

Behaviour:
Input synchronisation:
- uart_rx_in passes through a 2-flop synchroniser; its output is rx_s.
- Both flops reset to 1.
- All decisions use rx_s only.

Reset (cpu_resetn=0 at an edge):
- state=IDLE; counters=0; rx_data=8'h00; rx_valid=0; frame_err=0; overrun=0; busy=0.
- Reset mid-frame abandons the frame. No partial byte is ever delivered.

Bit counter and byte counter:
- cnt counts 0..CLKS_PER_BIT-1 and is cleared on every state change.
- bit_idx counts 0..7.

FSM:
- IDLE: if rx_s=0, go to START with cnt=0.
- START: when cnt==HALF_BIT-1, sample rx_s.
  - rx_s=1 (glitch): go to IDLE, nothing reported.
  - rx_s=0: go to DATA, bit_idx=0.
- DATA: when cnt==CLKS_PER_BIT-1, shift rx_s into shreg[bit_idx] (LSB first).
  - If bit_idx==7, go to STOP; otherwise bit_idx+1.
  - Every sample therefore lands at bit mid-point.
- STOP: when cnt==CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1, delivery rules:
    - If rx_valid==0, or (rx_valid && rx_ready) in the same cycle: rx_data<=shreg and rx_valid<=1.
    - Otherwise set overrun; the old rx_data/rx_valid are kept and the new byte is discarded.
    - Go to IDLE.
  - rx_s=0: frame_err=1 for exactly one cycle, byte discarded, go to RECOVER.
- RECOVER: wait for rx_s=1, then go to IDLE. A break condition (line held low) yields exactly one frame_err.

Handshake:
- rx_valid clears on the edge where rx_valid && rx_ready, unless a new byte loads on the same edge; in that case rx_valid stays 1 and rx_data updates.
- rx_data must not change while rx_valid=1 without acceptance.

Overrun clear:
- overrun clears on ovr_clr=1.
- If the set and clear conditions occur in the same cycle, set wins.

Latency:
- Nominal: rx_valid rises 2 + 1 + HALF_BIT + 9*CLKS_PER_BIT cycles after the first sysclk edge that samples uart_rx_in low.
- Bench tolerance: ±1 cycle.
- Back-to-back frames (stop bit immediately followed by the next start bit) must be received without loss.

Test Plan:
1. Reset, line idle, send 0xA5 at 87 clk/bit, rx_ready=0 → rx_valid=1 with rx_data=8'hA5 at nominal latency ±1; it stays 1 until rx_ready is pulsed, then clears next edge; frame_err=0, overrun=0.
2. Three back-to-back frames 0x00, 0xFF, 0x3C with rx_ready held 1 → three rx_valid pulses, each of exactly 1 cycle, with data 00/FF/3C in order; busy low only between frames.
3. 20-cycle low glitch on an idle line → no rx_valid, no frame_err; busy high for about HALF_BIT+1 cycles, then IDLE.
4. Frame 0x55 with stop bit forced low, then the line held low for 3 bit times before returning high → one frame_err pulse, no rx_valid; next frame 0x12 is received correctly.
5. Two frames 0x11, 0x22 with rx_ready=0 → rx_data stays 8'h11 and overrun=1 after the second frame; then assert ovr_clr together with a third frame's completion → overrun remains 1.
6. Assert cpu_resetn=0 for 1 cycle mid-DATA of frame 0x77 → all outputs reset, no byte delivered; next full frame 0x77 is received correctly.
